// File: rtl/btn_pulse_if.sv
// Button-side bundle for btn_pulse_gen: raw buttons in, debounced step pulses and held flags out.
// master drives the buttons and consumes pulses; slave is the pulse generator.
interface btn_pulse_if;
  logic btnL;
  logic btnR;
  logic pulseL;
  logic pulseR;
  logic heldL;
  logic heldR;

  modport master (
    output btnL,
    output btnR,
    input  pulseL,
    input  pulseR,
    input  heldL,
    input  heldR
  );

  modport slave (
    input  btnL,
    input  btnR,
    output pulseL,
    output pulseR,
    output heldL,
    output heldR
  );
endinterface

// File: rtl/btn_pulse_gen.sv
// Synchronise, debounce and turn btnL/btnR presses into single-cycle step pulses.
// Define AUTOREPEAT_EN to emit repeat pulses while a button stays held.
module btn_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  btn_pulse_if.slave btn
);

  typedef enum logic [2:0] {
    StIdle,
    StPressWait,
    StHeld,
`ifdef AUTOREPEAT_EN
    StRepeat,
`endif
    StReleaseWait
  } state_e;

  // Counts below 2 would let a second pulse land while the arbiter still holds one pending.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_min_check
    $error("btn_pulse_gen: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
  end
  if (((64'(DEBOUNCE_CYCLES) | 64'(REPEAT_DELAY) | 64'(REPEAT_PERIOD)) >> CNT_W) != 0)
  begin : g_width_check
    $error("btn_pulse_gen: CNT_W too narrow for the configured counts");
  end

  localparam logic [CNT_W-1:0] DbCount = CNT_W'(DEBOUNCE_CYCLES);
`ifdef AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(REPEAT_PERIOD - 1);
`endif

  // Index 0 is the left button, index 1 the right button.
  logic [1:0]       raw_btn;
  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  state_e           state_q [2];
  state_e           state_d [2];
  logic [CNT_W-1:0] timer_q [2];
  logic [CNT_W-1:0] timer_d [2];
  logic [1:0]       raw_pulse;
  logic [1:0]       held;
  logic             pulse_l_q, pulse_l_d;
  logic             pulse_r_q, pulse_r_d;
  logic             pend_q, pend_d;

  assign raw_btn = {btn.btnR, btn.btnL};

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_btn;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i]   = state_q[i];
      timer_d[i]   = timer_q[i];
      raw_pulse[i] = 1'b0;
      held[i]      = 1'b0;
      unique case (state_q[i])
        StIdle: begin
          if (sync2_q[i]) begin
            state_d[i] = StPressWait;
            timer_d[i] = CNT_W'(1);
          end
        end
        StPressWait: begin
          if (!sync2_q[i]) begin
            state_d[i] = StIdle;
            timer_d[i] = '0;
          end else if (timer_q[i] == DbCount) begin
            state_d[i]   = StHeld;
            timer_d[i]   = '0;
            raw_pulse[i] = 1'b1;
          end else begin
            timer_d[i] = timer_q[i] + 1'b1;
          end
        end
        StHeld: begin
          held[i] = 1'b1;
          if (!sync2_q[i]) begin
            state_d[i] = StReleaseWait;
            timer_d[i] = CNT_W'(1);
          end
`ifdef AUTOREPEAT_EN
          else if (timer_q[i] == DelayLast) begin
            state_d[i]   = StRepeat;
            timer_d[i]   = '0;
            raw_pulse[i] = 1'b1;
          end else begin
            timer_d[i] = timer_q[i] + 1'b1;
          end
`endif
        end
`ifdef AUTOREPEAT_EN
        StRepeat: begin
          held[i] = 1'b1;
          if (!sync2_q[i]) begin
            state_d[i] = StReleaseWait;
            timer_d[i] = CNT_W'(1);
          end else if (timer_q[i] == PeriodLast) begin
            timer_d[i]   = '0;
            raw_pulse[i] = 1'b1;
          end else begin
            timer_d[i] = timer_q[i] + 1'b1;
          end
        end
`endif
        StReleaseWait: begin
          held[i] = 1'b1;
          // A short high during release is bounce: resume holding without a new pulse.
          if (sync2_q[i]) begin
            state_d[i] = StHeld;
            timer_d[i] = '0;
          end else if (timer_q[i] == DbCount) begin
            state_d[i] = StIdle;
            timer_d[i] = '0;
          end else begin
            timer_d[i] = timer_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = StIdle;
          timer_d[i] = '0;
        end
      endcase
    end
  end

  // Left wins a tie; right goes out the following cycle. Counts >= 2 keep the slot free.
  always_comb begin
    pulse_l_d = raw_pulse[0];
    pulse_r_d = pend_q | (raw_pulse[1] & ~raw_pulse[0]);
    pend_d    = raw_pulse[1] & raw_pulse[0];
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= StIdle;
        timer_q[i] <= '0;
      end
      pulse_l_q <= 1'b0;
      pulse_r_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      pulse_l_q <= pulse_l_d;
      pulse_r_q <= pulse_r_d;
      pend_q    <= pend_d;
    end
  end

  assign btn.pulseL = pulse_l_q;
  assign btn.pulseR = pulse_r_q;
  assign btn.heldL  = held[0];
  assign btn.heldR  = held[1];

endmodule

// File: doc/btn_pulse_gen.md
Name: btn_pulse_gen

Overview:
Front end for the button-driven LED pattern blocks. Samples raw board buttons btnL/btnR, synchronises and debounces them, and produces single-cycle step pulses that the LED-position logic consumes directly. Optionally generates auto-repeat pulses while a button is held. The consumer needs no edge detection or debouncing of its own.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples required to accept a press or a release (10 ms at 100 MHz); minimum 2.
REPEAT_DELAY, 50000000, cycles from the first pulse to the first auto-repeat pulse (500 ms); minimum 2.
REPEAT_PERIOD, 10000000, cycles between successive auto-repeat pulses (100 ms); minimum 2.
CNT_W, 26, timer width; must hold the largest of the three counts above.

Ports:
CLK100MHZ  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
btnL  input  1  raw asynchronous left button, active high
btnR  input  1  raw asynchronous right button, active high
pulseL  output  1  one-cycle left step pulse
pulseR  output  1  one-cycle right step pulse
heldL  output  1  left button debounced as pressed
heldR  output  1  right button debounced as pressed

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clock CLK100MHZ, reset reset).
- Reset, sampled on a CLK100MHZ edge: pulseL=pulseR=heldL=heldR=0. Both synchronisers are cleared to 0, both FSMs go to IDLE, all timers are 0, and the arbitration pending flag is 0. This applies mid-operation too; any in-flight pulse is dropped. A button held through reset deassertion is debounced from scratch and yields exactly one pulse after the normal latency.
- Each button passes through a 2-flop synchroniser. One independent FSM and timer per button; both are identical.
- IDLE:
  - sync=1 -> PRESS_WAIT, timer=1.
- PRESS_WAIT:
  - sync=0 -> IDLE.
  - timer reaches DEBOUNCE_CYCLES -> HELD. Raw pulse is issued in the following cycle; timer=0.
- HELD: timer counts toward REPEAT_DELAY.
  - sync=0 -> RELEASE_WAIT, timer=1.
  - Expiry -> REPEAT. Raw pulse is issued; timer=0.
- REPEAT: timer counts toward REPEAT_PERIOD.
  - Each expiry issues a raw pulse and sets timer=0.
  - sync=0 -> RELEASE_WAIT.
- RELEASE_WAIT:
  - sync=1 before DEBOUNCE_CYCLES -> back to HELD with timer=0 and no pulse (glitch on release).
  - DEBOUNCE_CYCLES consecutive lows -> IDLE.
- heldX=1 in HELD, REPEAT and RELEASE_WAIT; heldX=0 otherwise.
- Latency: pin stable high -> pulseX asserted exactly DEBOUNCE_CYCLES+3 clocks later, held for exactly 1 cycle.
- Bounce shorter than DEBOUNCE_CYCLES on press produces no pulse. Bounce on release produces no extra pulse.
- Arbitration: pulseL and pulseR are never high in the same cycle.
  - If both raw pulses coincide, pulseL fires and pulseR is deferred exactly one cycle via the pending flag.
  - The deferred pulse is never lost.
  - Parameter minimum of 2 guarantees a second R pulse cannot arrive while one is pending.
- Timers saturate/clear as above and never wrap. Timer arithmetic is unsigned, CNT_W bits.

Optional Feature:
Macro AUTOREPEAT_EN.
- Defined: HELD/REPEAT auto-repeat behaviour exactly as above.
- Undefined: the REPEAT state and its timer logic are absent. HELD waits only for release, giving exactly one pulse per debounced press regardless of hold time. REPEAT_DELAY and REPEAT_PERIOD are ignored.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, with AUTOREPEAT_EN defined unless stated.)
- Reset and release: btnL held high from cycle 0, reset high cycles 0-2 -> all outputs 0 during reset; single pulseL at cycle 3+7=10; heldL=1 from then on.
- Press bounce: btnL toggled high 3 cycles / low 2 cycles repeatedly for 40 cycles, then low -> pulseL never asserted, heldL stays 0.
- Auto-repeat: btnR held 60 cycles -> pulseR at t0=7, t0+20=27, 35, 43, 51, 59; each pulse 1 cycle wide; heldR high until 4+2 cycles after release.
- Simultaneous press: btnL and btnR rise on the same edge -> pulseL at cycle 7, pulseR at cycle 8, never both high.
- Release glitch: btnL held 30 cycles, low 2 cycles, high again 10 cycles -> no extra pulseL; heldL remains 1 throughout; REPEAT_DELAY restarts.
- AUTOREPEAT_EN undefined: btnR held 100 cycles -> exactly one pulseR, at cycle 7.
